// File: rtl/wb_arbiter_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master request/response
// groups, the shared slave-side request/response and the arbiter status lines.
interface wb_arbiter_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = 4
);
    // master 0 (CPU) request and response
    logic [WB_ADDR_WIDTH-1:0] m0_addr_i;
    logic [WB_DATA_WIDTH-1:0] m0_data_i;
    logic                     m0_we_i;
    logic [WB_SEL_WIDTH-1:0]  m0_sel_i;
    logic                     m0_stb_i;
    logic                     m0_cyc_i;
    logic                     m0_ack_o;
    logic                     m0_err_o;
    logic [WB_DATA_WIDTH-1:0] m0_data_o;

    // master 1 (debug / loader) request and response
    logic [WB_ADDR_WIDTH-1:0] m1_addr_i;
    logic [WB_DATA_WIDTH-1:0] m1_data_i;
    logic                     m1_we_i;
    logic [WB_SEL_WIDTH-1:0]  m1_sel_i;
    logic                     m1_stb_i;
    logic                     m1_cyc_i;
    logic                     m1_ack_o;
    logic                     m1_err_o;
    logic [WB_DATA_WIDTH-1:0] m1_data_o;

    // shared slave-side bus
    logic [WB_ADDR_WIDTH-1:0] s_addr_o;
    logic [WB_DATA_WIDTH-1:0] s_data_o;
    logic                     s_we_o;
    logic [WB_SEL_WIDTH-1:0]  s_sel_o;
    logic                     s_stb_o;
    logic                     s_cyc_o;
    logic                     s_ack_i;
    logic [WB_DATA_WIDTH-1:0] s_data_i;

    // arbiter status
    logic [1:0]               grant_o;
    logic                     timeout_o;

    // arbiter's own view: it serves the masters and drives the slave bus
    modport slave (
        input  m0_addr_i, m0_data_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i,
        output m0_ack_o, m0_err_o, m0_data_o,
        input  m1_addr_i, m1_data_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i,
        output m1_ack_o, m1_err_o, m1_data_o,
        output s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        input  s_ack_i, s_data_i,
        output grant_o, timeout_o
    );

    // environment view: the masters plus the slave responder
    modport master (
        output m0_addr_i, m0_data_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i,
        input  m0_ack_o, m0_err_o, m0_data_o,
        output m1_addr_i, m1_data_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i,
        input  m1_ack_o, m1_err_o, m1_data_o,
        input  s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        output s_ack_i, s_data_i,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with a per-grant watchdog.
// A grant is held for a whole bus cycle; one idle cycle always separates
// grants. The watchdog aborts a transfer the slave never acknowledges.
module wb_arbiter #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    wb_arbiter_if.slave  bus
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam bit          WDOG_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state;
    logic        last;
    logic [15:0] wcnt;
    logic [1:0]  grant;

    logic        owner_cyc;
    logic        owner_stb;
    logic        abort;

    // select the current owner's cyc/stb and detect the watchdog abort cycle
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        case (state)
            GNT0: begin
                owner_cyc = bus.m0_cyc_i;
                owner_stb = bus.m0_stb_i;
            end
            GNT1: begin
                owner_cyc = bus.m1_cyc_i;
                owner_stb = bus.m1_stb_i;
            end
            default: begin
                owner_cyc = 1'b0;
                owner_stb = 1'b0;
            end
        endcase
        abort = WDOG_EN && (state != IDLE) && (wcnt == TIMEOUT_LIM) && !bus.s_ack_i;
    end

    // arbitration FSM, round-robin history, watchdog counter and grant register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            last  <= 1'b1;
            wcnt  <= 16'd0;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    wcnt <= 16'd0;
                    if (bus.m0_cyc_i && (!bus.m1_cyc_i || last)) begin
                        state <= GNT0;
                        grant <= 2'b01;
                        last  <= 1'b0;
                    end else if (bus.m1_cyc_i) begin
                        state <= GNT1;
                        grant <= 2'b10;
                        last  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (abort) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        wcnt  <= 16'd0;
                    end else begin
                        if (bus.s_ack_i) begin
                            wcnt <= 16'd0;
                        end else if (owner_stb) begin
                            wcnt <= wcnt + 16'd1;
                        end
                        if (!owner_cyc) begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                    wcnt  <= 16'd0;
                end
            endcase
        end
    end

    // route the owner's request to the slave and the slave's response back
    always_comb begin
        bus.s_addr_o  = {WB_ADDR_WIDTH{1'b0}};
        bus.s_data_o  = {WB_DATA_WIDTH{1'b0}};
        bus.s_sel_o   = {WB_SEL_WIDTH{1'b0}};
        bus.s_we_o    = 1'b0;
        bus.s_cyc_o   = 1'b0;
        bus.s_stb_o   = 1'b0;
        bus.m0_ack_o  = 1'b0;
        bus.m0_err_o  = 1'b0;
        bus.m0_data_o = {WB_DATA_WIDTH{1'b0}};
        bus.m1_ack_o  = 1'b0;
        bus.m1_err_o  = 1'b0;
        bus.m1_data_o = {WB_DATA_WIDTH{1'b0}};
        case (state)
            GNT0: begin
                bus.s_addr_o  = bus.m0_addr_i;
                bus.s_data_o  = bus.m0_data_i;
                bus.s_sel_o   = bus.m0_sel_i;
                bus.s_we_o    = bus.m0_we_i;
                bus.s_cyc_o   = bus.m0_cyc_i && !abort;
                bus.s_stb_o   = bus.m0_stb_i && !abort;
                bus.m0_ack_o  = bus.s_ack_i;
                bus.m0_err_o  = abort;
                bus.m0_data_o = bus.s_data_i;
            end
            GNT1: begin
                bus.s_addr_o  = bus.m1_addr_i;
                bus.s_data_o  = bus.m1_data_i;
                bus.s_sel_o   = bus.m1_sel_i;
                bus.s_we_o    = bus.m1_we_i;
                bus.s_cyc_o   = bus.m1_cyc_i && !abort;
                bus.s_stb_o   = bus.m1_stb_i && !abort;
                bus.m1_ack_o  = bus.s_ack_i;
                bus.m1_err_o  = abort;
                bus.m1_data_o = bus.s_data_i;
            end
            default: begin
                bus.s_cyc_o = 1'b0;
            end
        endcase
    end

    assign bus.grant_o   = grant;
    assign bus.timeout_o = abort;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;

    int n_checks  = 0;
    int n_fail    = 0;
    int rst_edges = 0;

    wb_arbiter_if #(.WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW)) bus ();

    wb_arbiter #(
        .WB_DATA_WIDTH (DW),
        .WB_ADDR_WIDTH (AW),
        .WB_SEL_WIDTH  (SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    // free-running clock
    always #5 clk_i = ~clk_i;

    // count reset assertions so the model notices even short pulses
    always @(negedge rst_n_i) rst_edges++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input int m, input logic cyc, input logic stb, input logic we,
                                  input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                  input logic [SW-1:0] sel);
        if (m == 0) begin
            bus.m0_cyc_i = cyc; bus.m0_stb_i = stb; bus.m0_we_i = we;
            bus.m0_addr_i = addr; bus.m0_data_i = data; bus.m0_sel_i = sel;
        end else begin
            bus.m1_cyc_i = cyc; bus.m1_stb_i = stb; bus.m1_we_i = we;
            bus.m1_addr_i = addr; bus.m1_data_i = data; bus.m1_sel_i = sel;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_master(input int m);
        apply_stimulus(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic req_master(input int m, input logic [AW-1:0] addr);
        apply_stimulus(m, 1'b1, 1'b1, 1'b0, addr, 32'hA5A5_0000 + 32'(m), 4'hF);
    endtask

    // behavioural model: owner is -1 when the bus is free; stall counts
    // unacknowledged strobe cycles of the current grant
    initial begin : model_compare
        int owner;
        bit last;
        int stall;
        int rst_handled;
        bit abort;
        logic mc[2];
        logic ms[2];
        logic mw[2];
        logic [31:0] ma[2];
        logic [31:0] md[2];
        logic [31:0] msel[2];
        logic [31:0] e_addr, e_data, e_sel, e_grant;
        logic e_we, e_cyc, e_stb, e_timeout;
        logic e_ack[2];
        logic e_err[2];
        logic [31:0] e_rdata[2];
        owner = -1; last = 1'b1; stall = 0; rst_handled = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i || rst_edges != rst_handled) begin
                owner = -1; last = 1'b1; stall = 0; rst_handled = rst_edges;
            end
            mc[0] = bus.m0_cyc_i; ms[0] = bus.m0_stb_i; mw[0] = bus.m0_we_i;
            ma[0] = 32'(bus.m0_addr_i); md[0] = 32'(bus.m0_data_i); msel[0] = 32'(bus.m0_sel_i);
            mc[1] = bus.m1_cyc_i; ms[1] = bus.m1_stb_i; mw[1] = bus.m1_we_i;
            ma[1] = 32'(bus.m1_addr_i); md[1] = 32'(bus.m1_data_i); msel[1] = 32'(bus.m1_sel_i);
            abort = (owner >= 0) && (TO != 0) && (stall == TO) && !bus.s_ack_i;
            e_addr = '0; e_data = '0; e_sel = '0; e_grant = '0;
            e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_timeout = 1'b0;
            for (int m = 0; m < 2; m++) begin
                e_ack[m] = 1'b0; e_err[m] = 1'b0; e_rdata[m] = '0;
            end
            if (owner >= 0) begin
                e_addr = ma[owner]; e_data = md[owner]; e_sel = msel[owner]; e_we = mw[owner];
                e_cyc = mc[owner] && !abort;
                e_stb = ms[owner] && !abort;
                e_ack[owner] = bus.s_ack_i;
                e_err[owner] = abort;
                e_rdata[owner] = 32'(bus.s_data_i);
                e_grant = (owner == 0) ? 32'd1 : 32'd2;
                e_timeout = abort;
            end
            check_output("s_addr", 32'(bus.s_addr_o), e_addr);
            check_output("s_data", 32'(bus.s_data_o), e_data);
            check_output("s_sel", 32'(bus.s_sel_o), e_sel);
            check_output("s_we", 32'(bus.s_we_o), 32'(e_we));
            check_output("s_cyc", 32'(bus.s_cyc_o), 32'(e_cyc));
            check_output("s_stb", 32'(bus.s_stb_o), 32'(e_stb));
            check_output("m0_ack", 32'(bus.m0_ack_o), 32'(e_ack[0]));
            check_output("m0_err", 32'(bus.m0_err_o), 32'(e_err[0]));
            check_output("m0_data", 32'(bus.m0_data_o), e_rdata[0]);
            check_output("m1_ack", 32'(bus.m1_ack_o), 32'(e_ack[1]));
            check_output("m1_err", 32'(bus.m1_err_o), 32'(e_err[1]));
            check_output("m1_data", 32'(bus.m1_data_o), e_rdata[1]);
            check_output("grant", 32'(bus.grant_o), e_grant);
            check_output("timeout", 32'(bus.timeout_o), 32'(e_timeout));
            if (rst_n_i) begin
                if (owner < 0) begin
                    stall = 0;
                    if (mc[0] && mc[1]) owner = last ? 0 : 1;
                    else if (mc[0]) owner = 0;
                    else if (mc[1]) owner = 1;
                    if (owner >= 0) last = (owner == 1);
                end else if (abort) begin
                    owner = -1;
                    stall = 0;
                end else begin
                    if (bus.s_ack_i) stall = 0;
                    else if (ms[owner]) stall++;
                    if (!mc[owner]) owner = -1;
                end
            end
        end
    end

    // directed scenarios followed by randomized traffic
    initial begin : stimulus
        idle_master(0);
        idle_master(1);
        bus.s_ack_i  = 1'b0;
        bus.s_data_i = '0;
        repeat (2) @(posedge clk_i);
        #2;
        check_output("rst_grant", 32'(bus.grant_o), 32'd0);
        check_output("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
        check_output("rst_timeout", 32'(bus.timeout_o), 32'd0);

        // single read by m0, slave acks two cycles after the strobe
        tick();
        rst_n_i = 1'b1;
        req_master(0, 32'h0);
        #1;
        check_output("t1_idle_grant", 32'(bus.grant_o), 32'd0);
        check_output("t1_idle_cyc", 32'(bus.s_cyc_o), 32'd0);
        tick(); #1;
        check_output("t1_grant", 32'(bus.grant_o), 32'd1);
        check_output("t1_s_cyc", 32'(bus.s_cyc_o), 32'd1);
        check_output("t1_s_addr", 32'(bus.s_addr_o), 32'd0);
        check_output("t1_no_early_ack", 32'(bus.m0_ack_o), 32'd0);
        tick();
        bus.s_ack_i = 1'b1; bus.s_data_i = 32'h1234_5678;
        #1;
        check_output("t1_ack", 32'(bus.m0_ack_o), 32'd1);
        check_output("t1_rdata", 32'(bus.m0_data_o), 32'h1234_5678);
        check_output("t1_m1_data", 32'(bus.m1_data_o), 32'd0);
        tick();
        bus.s_ack_i = 1'b0; bus.s_data_i = '0;
        idle_master(0);
        #1;
        check_output("t1_ack_single", 32'(bus.m0_ack_o), 32'd0);
        check_output("t1_grant_hold", 32'(bus.grant_o), 32'd1);
        tick(); #1;
        check_output("t1_grant_release", 32'(bus.grant_o), 32'd0);

        // simultaneous requests out of reset: m0 first, then m1
        rst_n_i = 1'b0; #2; rst_n_i = 1'b1;
        req_master(0, 32'h100);
        req_master(1, 32'h200);
        tick(); #1;
        check_output("t2_first_m0", 32'(bus.grant_o), 32'd1);
        bus.s_ack_i = 1'b1;
        #1;
        check_output("t2_m0_ack", 32'(bus.m0_ack_o), 32'd1);
        check_output("t2_m1_blocked", 32'(bus.m1_ack_o), 32'd0);
        tick();
        bus.s_ack_i = 1'b0;
        idle_master(0);
        tick(); #1;
        check_output("t2_idle_gap", 32'(bus.grant_o), 32'd0);
        check_output("t2_idle_cyc", 32'(bus.s_cyc_o), 32'd0);
        tick(); #1;
        check_output("t2_then_m1", 32'(bus.grant_o), 32'd2);
        bus.s_ack_i = 1'b1;
        #1;
        check_output("t2_m1_ack", 32'(bus.m1_ack_o), 32'd1);
        check_output("t2_m0_no_ack", 32'(bus.m0_ack_o), 32'd0);
        tick();
        bus.s_ack_i = 1'b0;
        idle_master(1);
        tick(); #1;
        check_output("t2_end_idle", 32'(bus.grant_o), 32'd0);

        // round robin: m0 re-requests back to back while m1 keeps asking
        req_master(0, 32'h300);
        req_master(1, 32'h400);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check_output("t3_rr_grant", 32'(bus.grant_o), (k % 2 == 0) ? 32'd1 : 32'd2);
            bus.s_ack_i = 1'b1;
            #1;
            check_output("t3_other_no_ack", (k % 2 == 0) ? 32'(bus.m1_ack_o) : 32'(bus.m0_ack_o), 32'd0);
            tick();
            bus.s_ack_i = 1'b0;
            idle_master(k % 2);
            tick(); #1;
            check_output("t3_idle_between", 32'(bus.grant_o), 32'd0);
            if (k < 3) req_master(k % 2, 32'h300 + 32'(k));
            else idle_master(0);
        end

        // watchdog abort on m1; m0 waits and is granted afterwards
        req_master(1, 32'h500);
        tick(); #1;
        for (int i = 1; i <= 4; i++) begin
            check_output("t4_wait_err", 32'(bus.m1_err_o), 32'd0);
            check_output("t4_wait_timeout", 32'(bus.timeout_o), 32'd0);
            check_output("t4_wait_cyc", 32'(bus.s_cyc_o), 32'd1);
            if (i == 2) req_master(0, 32'h600);
            tick(); #1;
        end
        check_output("t4_err", 32'(bus.m1_err_o), 32'd1);
        check_output("t4_timeout", 32'(bus.timeout_o), 32'd1);
        check_output("t4_cyc_forced", 32'(bus.s_cyc_o), 32'd0);
        check_output("t4_stb_forced", 32'(bus.s_stb_o), 32'd0);
        check_output("t4_no_ack", 32'(bus.m1_ack_o), 32'd0);
        tick(); #1;
        check_output("t4_idle_after", 32'(bus.grant_o), 32'd0);
        check_output("t4_pulse_once", 32'(bus.timeout_o), 32'd0);
        tick(); #1;
        check_output("t4_m0_next", 32'(bus.grant_o), 32'd1);
        bus.s_ack_i = 1'b1;
        tick();
        bus.s_ack_i = 1'b0;
        idle_master(0);
        idle_master(1);
        tick();

        // ack arrives exactly in the abort cycle: ack wins
        req_master(0, 32'h700);
        tick(); #1;
        for (int i = 1; i <= 4; i++) begin
            check_output("t5_wait_err", 32'(bus.m0_err_o), 32'd0);
            tick(); #1;
        end
        bus.s_ack_i = 1'b1;
        #1;
        check_output("t5_ack", 32'(bus.m0_ack_o), 32'd1);
        check_output("t5_no_err", 32'(bus.m0_err_o), 32'd0);
        check_output("t5_no_timeout", 32'(bus.timeout_o), 32'd0);
        check_output("t5_cyc", 32'(bus.s_cyc_o), 32'd1);
        tick();
        bus.s_ack_i = 1'b0;
        idle_master(0);
        tick();

        // asynchronous reset while m1 owns the bus
        req_master(1, 32'h800);
        tick(); #1;
        check_output("t6_m1_owner", 32'(bus.grant_o), 32'd2);
        #1;
        rst_n_i = 1'b0;
        bus.s_ack_i = 1'b1;
        #1;
        check_output("t6_grant_drop", 32'(bus.grant_o), 32'd0);
        check_output("t6_cyc_drop", 32'(bus.s_cyc_o), 32'd0);
        check_output("t6_stb_drop", 32'(bus.s_stb_o), 32'd0);
        check_output("t6_no_ack", 32'(bus.m1_ack_o), 32'd0);
        rst_n_i = 1'b1;
        bus.s_ack_i = 1'b0;
        req_master(0, 32'h900);
        tick(); #1;
        check_output("t6_tie_m0", 32'(bus.grant_o), 32'd1);
        idle_master(0);
        idle_master(1);
        tick();

        // randomized traffic with varying slave responsiveness
        for (int n = 0; n < 3000; n++) begin
            int phase;
            int ack_pct;
            logic cur;
            logic nc;
            tick();
            phase = (n / 250) % 3;
            ack_pct = (phase == 0) ? 0 : ((phase == 1) ? 50 : 15);
            for (int m = 0; m < 2; m++) begin
                cur = (m == 0) ? bus.m0_cyc_i : bus.m1_cyc_i;
                nc = cur ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
                apply_stimulus(m, nc, nc && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                               AW'($urandom), DW'($urandom), SW'($urandom_range(0, 15)));
            end
            bus.s_ack_i = ($urandom_range(0, 99) < ack_pct);
            bus.s_data_i = DW'($urandom);
        end
        tick();
        idle_master(0);
        idle_master(1);
        bus.s_ack_i = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master Wishbone arbiter that shares the SoC slave bus (the input side of the address mux) between the CPU (master 0) and a second bus master such as a debug/firmware loader (master 1). Grants are round-robin and held for a whole bus cycle. A watchdog ends any transfer the addressed slave never acknowledges, so neither master can hang the interconnect. Sits between the masters and the mux; the mux and slaves are unchanged.

## Interface
Parameters:
- WB_DATA_WIDTH, 32, data width
- WB_ADDR_WIDTH, 32, address width
- WB_SEL_WIDTH, 4, byte-select width
- TIMEOUT_CYCLES, 255, wait cycles before abort; 1..65535; 0 disables the watchdog

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- mN_addr_i, mN_data_i, mN_we_i, mN_sel_i, mN_stb_i, mN_cyc_i  in  WB widths  master N request (N = 0, 1)
- mN_ack_o  out  1  master N acknowledge
- mN_err_o  out  1  master N timeout error
- mN_data_o  out  WB_DATA_WIDTH  master N read data
- s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o  out  WB widths  slave-side request
- s_ack_i  in  1  slave acknowledge
- s_data_i  in  WB_DATA_WIDTH  slave read data
- grant_o  out  2  one-hot current owner (bit N = master N), 00 when idle
- timeout_o  out  1  one-cycle pulse on a watchdog abort

## Operation
- FSM states: IDLE, GNT0, GNT1. Register `last` holds the most recently granted master. Reset value of `last` is 1, so master 0 wins the first tie.
- IDLE:
  - Only one mN_cyc_i high → GNTN.
  - Both high → grant the master other than `last`.
  - Neither high → stay in IDLE.
  - s_cyc_o, s_stb_o, s_we_o = 0.
  - s_addr_o, s_data_o, s_sel_o = 0.
- GNTN:
  - s_* outputs forward master N's request combinationally.
  - mN_ack_o = s_ack_i; mN_data_o = s_data_i.
  - The other master sees ack = 0, err = 0, data = 0.
  - `last` <= N on entry.
- Leaving GNTN:
  - mN_cyc_i low → IDLE on the next edge. There is always one IDLE cycle between grants, including back-to-back.
  - Watchdog abort → IDLE, regardless of cyc.
  - Requests arriving while a grant is held wait; the current grant is never preempted.
- Watchdog:
  - 16-bit counter `wcnt`. Cleared in IDLE and on every cycle with s_ack_i = 1.
  - Increments in GNTN each cycle with mN_stb_i = 1 and s_ack_i = 0.
  - Abort cycle: the cycle where `wcnt == TIMEOUT_CYCLES` and s_ack_i = 0, with TIMEOUT_CYCLES ≠ 0. In that cycle:
    - mN_err_o = 1, mN_ack_o = 0, timeout_o = 1.
    - s_cyc_o and s_stb_o are forced 0.
    - Next state IDLE, `wcnt` <= 0.
  - A master still holding cyc after an error re-enters arbitration normally.
- Simultaneous events:
  - s_ack_i and the watchdog limit in the same cycle → ack wins, no error.
  - mN_cyc_i falling in the same cycle as a late ack → ack is still forwarded.
- Reset mid-transfer: all state cleared immediately and asynchronously; the slave sees cyc/stb drop with no ack or err reaching the master.
- Reset values:
  - State IDLE, grant_o = 00, timeout_o = 0.
  - All ack, err, cyc, stb outputs 0; all data outputs 0.

## Timing
- Grant latency: request with cyc high in IDLE → s_cyc_o high on the next cycle (1 cycle).
- Data path: ack and read data pass slave→master combinationally (0 cycles). Request fields pass master→slave combinationally while granted.
- Pipelined or burst accesses inside one cyc are forwarded unchanged; the watchdog restarts at each ack.
- Abort timing: error appears in the (TIMEOUT_CYCLES+1)-th consecutive unacknowledged stb cycle of the grant.
- grant_o is registered and matches the FSM state.
- timeout_o is combinational from the FSM state and `wcnt`, high for exactly one cycle.

## Test plan
- Reset, then m0 reads address 0x0 (slave acks 2 cycles after stb) → s_cyc_o high 1 cycle after m0_cyc_i; m0_ack_o high 1 cycle with slave data 0x12345678; grant_o 01 → 00.
- m0 and m1 raise cyc in the same cycle out of reset → m0 granted first. After m0 drops cyc: 1 IDLE cycle, then grant_o = 10 and m1 served.
- m0 issues 3 back-to-back transfers while m1 holds cyc → grants alternate m0, m1, m0, m1 (round-robin), each separated by one IDLE cycle; m1 never ack'd while m0 owns the bus.
- TIMEOUT_CYCLES = 4, slave never acks m1 → m1_err_o and timeout_o high in the 5th stb cycle; s_cyc_o low in that cycle; FSM IDLE next; m0 is then granted normally.
- TIMEOUT_CYCLES = 4, slave acks exactly in the 5th stb cycle → ack forwarded, no err, no timeout_o.
- rst_n_i pulsed low mid-transfer while granted to m1 → grant_o, s_cyc_o and s_stb_o fall without waiting for a clock edge; after release, m0 wins the first tie.
